wb_slave_decoder: RTL and testbench

//  Parametrised Wishbone B4-pipelined decoder/return mux between hbbus master and N slaves.

---
 rtl/wb_slave_decoder_if.sv | 52 +++++
 rtl/wb_slave_decoder.sv | 154 +++++++++++++++
 tb/tb_wb_slave_decoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_decoder_if.sv
// Wishbone B4-pipelined bundle between an hbbus master, the decoder and its
// N slaves. The master-side request/response and the per-slave fan-out share
// one interface so the decoder exposes a single bus port.
interface wb_slave_decoder_if #(
  parameter int NSLAVES = 4,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int SAW     = 2
);

  // Master request
  logic                   i_wb_cyc;
  logic                   i_wb_stb;
  logic                   i_wb_we;
  logic [AW-1:0]          i_wb_addr;
  logic [DW-1:0]          i_wb_data;
  logic [DW/8-1:0]        i_wb_sel;

  // Master response
  logic                   o_wb_stall;
  logic                   o_wb_ack;
  logic                   o_wb_err;
  logic [DW-1:0]          o_wb_data;

  // Slave fan-out (cyc/stb one-hot, the rest broadcast)
  logic [NSLAVES-1:0]     o_s_cyc;
  logic [NSLAVES-1:0]     o_s_stb;
  logic                   o_s_we;
  logic [SAW-1:0]         o_s_addr;
  logic [DW-1:0]          o_s_data;
  logic [DW/8-1:0]        o_s_sel;

  // Slave responses; slave k read data sits at [k*DW +: DW]
  logic [NSLAVES-1:0]     i_s_stall;
  logic [NSLAVES-1:0]     i_s_ack;
  logic [NSLAVES*DW-1:0]  i_s_data;

  // Bus master view: drives requests, receives responses
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );

  // Decoder view: slave of the master bus, master of the N slaves
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  i_s_stall, i_s_ack, i_s_data
  );

endinterface

// File: rtl/wb_slave_decoder.sv
// Wishbone B4-pipelined address decoder and return mux.
// Page k+1 of the master address space belongs to slave k; page 0 is the
// null page and answers every strobe with a one-cycle error. Requests to a
// different slave are held off while another slave still owes acks, so
// responses always return in issue order. A watchdog aborts a transfer that
// goes TIMEOUT cycles without an ack, and every error is logged.
module wb_slave_decoder #(
  parameter int NSLAVES = 4,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int SAW     = 2,
  parameter int MAXOUT  = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_slave_decoder_if.slave    bus,
  output logic [AW-1:0]        o_err_addr,
  output logic [15:0]          o_err_count
);

  localparam int PW = AW - SAW;
  localparam int OW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CW = $clog2(MAXOUT + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic [PW-1:0]      page;
  logic [NSLAVES-1:0] hit;
  logic [OW-1:0]      hit_idx;
  logic               any_hit;
  logic               none_sel;

  logic [OW-1:0]      owner;
  logic [NSLAVES-1:0] owner_oh;
  logic [CW-1:0]      outstanding;
  logic               busy;
  logic [TW-1:0]      timer;
  logic               abort;
  logic [AW-1:0]      last_addr;

  logic               lock;
  logic               full;
  logic               block;
  logic               stall;
  logic               accept;
  logic               ack_in;
  logic               dec_err;
  logic               timeout;

  logic [1:0]         err_inc;
  logic [16:0]        err_sum;

  assign page     = bus.i_wb_addr[AW-1:SAW];
  assign any_hit  = |hit;
  assign none_sel = ~any_hit;

  // Page decode to a one-hot select plus the matching slave index
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NSLAVES; k++) begin
      if (page == PW'(k + 1)) begin
        hit[k]  = 1'b1;
        hit_idx = OW'(k);
      end
    end
  end

  assign owner_oh = NSLAVES'(1) << owner;
  assign busy     = (outstanding != '0);

  // Ordering lock: a new slave may only be addressed once the current
  // owner has returned every ack. Null-page strobes bypass the lock, the
  // full check and the abort hold, so they never stall.
  assign lock  = busy & any_hit & (hit != owner_oh);
  assign full  = any_hit & (outstanding == CW'(MAXOUT));
  // Slave strobes are gated by every stall source that the decoder itself
  // raises, so a slave never accepts a beat the master sees as stalled.
  assign block = lock | full | (any_hit & abort);
  assign stall = block | (|(hit & bus.i_s_stall));

  assign accept  = bus.i_wb_cyc & bus.i_wb_stb & any_hit & ~stall;
  assign ack_in  = busy & (|(bus.i_s_ack & owner_oh));
  assign dec_err = bus.i_wb_cyc & bus.i_wb_stb & none_sel;
  assign timeout = bus.i_wb_cyc & busy & ~ack_in & (timer == TW'(TIMEOUT - 1));

  assign bus.o_wb_stall = stall;
  assign bus.o_s_stb    = {NSLAVES{bus.i_wb_cyc & bus.i_wb_stb & ~block}} & hit;
  assign bus.o_s_cyc    = {NSLAVES{bus.i_wb_cyc & ~abort}}
                        & (({NSLAVES{busy}} & owner_oh) | hit);
  assign bus.o_s_we     = bus.i_wb_we;
  assign bus.o_s_addr   = bus.i_wb_addr[SAW-1:0];
  assign bus.o_s_data   = bus.i_wb_data;
  assign bus.o_s_sel    = bus.i_wb_sel;

  // Transaction bookkeeping: owner, outstanding count, watchdog, abort
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      owner       <= '0;
      outstanding <= '0;
      timer       <= '0;
      abort       <= 1'b0;
      last_addr   <= '0;
    end else begin
      abort <= timeout;
      if (accept) begin
        owner     <= hit_idx;
        last_addr <= bus.i_wb_addr;
      end
      if (~bus.i_wb_cyc | timeout)
        outstanding <= '0;
      else
        outstanding <= outstanding + CW'(accept) - CW'(ack_in);
      if (~bus.i_wb_cyc | ~busy | ack_in | timeout)
        timer <= '0;
      else
        timer <= timer + TW'(1);
    end
  end

  // Registered return path: only the owner's ack and data reach the master
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_wb_ack  <= 1'b0;
      bus.o_wb_data <= '0;
    end else begin
      bus.o_wb_ack  <= ack_in & bus.i_wb_cyc;
      bus.o_wb_data <= (ack_in & bus.i_wb_cyc) ? bus.i_s_data[int'(owner)*DW +: DW] : '0;
    end
  end

  // Saturating error count; both sources in one cycle add two
  always_comb begin
    err_inc = {1'b0, dec_err} + {1'b0, timeout};
    err_sum = {1'b0, o_err_count} + 17'(err_inc);
  end

  // Error pulse and capture; a decode error's address wins over a timeout
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_wb_err <= 1'b0;
      o_err_addr   <= '0;
      o_err_count  <= '0;
    end else begin
      bus.o_wb_err <= dec_err | timeout;
      if (dec_err)
        o_err_addr <= bus.i_wb_addr;
      else if (timeout)
        o_err_addr <= last_addr;
      o_err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Directed bench for wb_slave_decoder: single read, decode errors, ordering
// lock across slaves, watchdog abort, outstanding limit, cyc drop and reset.
module tb_wb_slave_decoder;

  localparam int NSLAVES = 4;
  localparam int AW      = 30;
  localparam int DW      = 32;
  localparam int SAW     = 2;

  logic           clk;
  logic           rst;
  logic [AW-1:0]  err_addr;
  logic [15:0]    err_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_slave_decoder_if #(.NSLAVES(NSLAVES), .AW(AW), .DW(DW), .SAW(SAW)) bus ();

  wb_slave_decoder #(
    .NSLAVES(NSLAVES),
    .AW(AW),
    .DW(DW),
    .SAW(SAW),
    .MAXOUT(7),
    .TIMEOUT(16)
  ) u_dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus),
    .o_err_addr(err_addr),
    .o_err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = 32'h0BAD_F00D;
    bus.i_wb_sel  = 4'hF;
    bus.i_s_stall = '0;
    bus.i_s_ack   = '0;
    bus.i_s_data  = '0;

    // Reset state
    tick();
    tick();
    check("rst_ack",   bus.o_wb_ack,  1'b0);
    check("rst_err",   bus.o_wb_err,  1'b0);
    check("rst_data",  bus.o_wb_data, 32'h0);
    check("rst_eaddr", err_addr,      30'h0);
    check("rst_ecnt",  err_count,     16'h0);
    check("rst_scyc",  bus.o_s_cyc,   4'b0000);
    #1 rst = 1'b0;
    tick();

    // Single read from slave0, ack three cycles after accept
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h4;
    settle();
    check("t1_sstb",  bus.o_s_stb,    4'b0001);
    check("t1_scyc",  bus.o_s_cyc,    4'b0001);
    check("t1_stall", bus.o_wb_stall, 1'b0);
    check("t1_addr",  bus.o_s_addr,   2'b00);
    tick();
    bus.i_wb_stb = 1'b0;
    tick();
    tick();
    check("t1_noack", bus.o_wb_ack, 1'b0);
    bus.i_s_ack         = 4'b0001;
    bus.i_s_data[31:0]  = 32'hDEADBEEF;
    tick();
    check("t1_ack",  bus.o_wb_ack,  1'b1);
    check("t1_data", bus.o_wb_data, 32'hDEADBEEF);
    bus.i_s_ack = 4'b0000;
    tick();
    check("t1_ack_clr",  bus.o_wb_ack,  1'b0);
    check("t1_data_clr", bus.o_wb_data, 32'h0);
    // Stray ack with nothing outstanding
    bus.i_s_ack = 4'b0001;
    tick();
    check("t1_stray", bus.o_wb_ack, 1'b0);
    bus.i_s_ack = 4'b0000;

    // Decode errors on the null page
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 30'h0;
    bus.i_wb_stb  = 1'b1;
    settle();
    check("t2_sstb",  bus.o_s_stb,    4'b0000);
    check("t2_stall", bus.o_wb_stall, 1'b0);
    tick();
    bus.i_wb_stb = 1'b0;
    check("t2_err",   bus.o_wb_err, 1'b1);
    check("t2_eaddr", err_addr,     30'h0);
    check("t2_ecnt",  err_count,    16'd1);
    tick();
    check("t2_err_clr", bus.o_wb_err, 1'b0);
    bus.i_wb_addr = 30'h3;
    bus.i_wb_stb  = 1'b1;
    tick();
    bus.i_wb_stb = 1'b0;
    check("t2b_eaddr", err_addr,  30'h3);
    check("t2b_ecnt",  err_count, 16'd2);
    bus.i_wb_we = 1'b0;

    // Three strobes to slave1, then slave2 held by the ordering lock
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h8;
    tick();
    bus.i_wb_addr = 30'h9;
    tick();
    bus.i_wb_addr = 30'hA;
    tick();
    bus.i_wb_addr = 30'hC;
    settle();
    check("t3_stall", bus.o_wb_stall, 1'b1);
    check("t3_sstb",  bus.o_s_stb,    4'b0000);
    check("t3_scyc",  bus.o_s_cyc,    4'b0110);
    bus.i_s_ack         = 4'b0110;
    bus.i_s_data[63:32] = 32'h11111111;
    bus.i_s_data[95:64] = 32'h99999999;
    tick();
    check("t3_ack1",  bus.o_wb_ack,   1'b1);
    check("t3_data1", bus.o_wb_data,  32'h11111111);
    check("t3_hold",  bus.o_wb_stall, 1'b1);
    bus.i_s_ack         = 4'b0010;
    bus.i_s_data[63:32] = 32'h22222222;
    tick();
    check("t3_ack2",  bus.o_wb_ack,  1'b1);
    check("t3_data2", bus.o_wb_data, 32'h22222222);
    bus.i_s_data[63:32] = 32'h33333333;
    tick();
    check("t3_ack3",  bus.o_wb_ack,  1'b1);
    check("t3_data3", bus.o_wb_data, 32'h33333333);
    bus.i_s_ack = 4'b0000;
    settle();
    check("t3_release", bus.o_wb_stall, 1'b0);
    check("t3_sstb2",   bus.o_s_stb,    4'b0100);
    tick();
    bus.i_wb_stb        = 1'b0;
    bus.i_s_ack         = 4'b0100;
    bus.i_s_data[95:64] = 32'h44444444;
    tick();
    check("t3_ack4",  bus.o_wb_ack,  1'b1);
    check("t3_data4", bus.o_wb_data, 32'h44444444);
    bus.i_s_ack = 4'b0000;

    // Watchdog: slave0 never acks
    bus.i_wb_addr = 30'h5;
    bus.i_wb_stb  = 1'b1;
    tick();
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_addr = 30'h6;
    repeat (15) tick();
    check("t4_noerr",   bus.o_wb_err, 1'b0);
    check("t4_scyc_pre", bus.o_s_cyc, 4'b0001);
    tick();
    check("t4_err",        bus.o_wb_err, 1'b1);
    check("t4_scyc_abort", bus.o_s_cyc,  4'b0000);
    check("t4_eaddr",      err_addr,     30'h5);
    check("t4_ecnt",       err_count,    16'd3);
    tick();
    check("t4_err_clr",    bus.o_wb_err, 1'b0);
    check("t4_scyc_post",  bus.o_s_cyc,  4'b0001);
    bus.i_s_ack = 4'b0001;
    tick();
    check("t4_late_ack",  bus.o_wb_ack, 1'b0);
    check("t4_ecnt_late", err_count,    16'd3);
    bus.i_s_ack = 4'b0000;

    // Outstanding limit on slave3
    bus.i_wb_addr = 30'h10;
    bus.i_wb_stb  = 1'b1;
    repeat (7) tick();
    check("t5_full",  bus.o_wb_stall, 1'b1);
    check("t5_sstb",  bus.o_s_stb,    4'b0000);
    bus.i_s_ack          = 4'b1000;
    bus.i_s_data[127:96] = 32'h55555555;
    settle();
    check("t5_full_ack", bus.o_wb_stall, 1'b1);
    tick();
    check("t5_ack",  bus.o_wb_ack,  1'b1);
    check("t5_data", bus.o_wb_data, 32'h55555555);
    bus.i_s_ack = 4'b0000;
    settle();
    check("t5_release", bus.o_wb_stall, 1'b0);
    check("t5_sstb8",   bus.o_s_stb,    4'b1000);
    tick();
    bus.i_wb_stb = 1'b0;
    settle();
    check("t5_refull", bus.o_wb_stall, 1'b1);
    // Master drops cyc: pending acks are discarded
    bus.i_wb_cyc = 1'b0;
    bus.i_s_ack  = 4'b1000;
    tick();
    check("t5_drop_ack", bus.o_wb_ack, 1'b0);
    bus.i_wb_cyc = 1'b1;
    bus.i_s_ack  = 4'b0000;
    settle();
    check("t5_drained", bus.o_wb_stall, 1'b0);
    check("t5_scyc",    bus.o_s_cyc,    4'b1000);

    // Reset with two requests outstanding
    check("t6_pre_ecnt", err_count, 16'd3);
    bus.i_wb_addr = 30'h4;
    bus.i_wb_stb  = 1'b1;
    tick();
    tick();
    bus.i_wb_stb        = 1'b0;
    bus.i_s_ack         = 4'b0001;
    bus.i_s_data[31:0]  = 32'hAAAA5555;
    tick();
    check("t6_ack_pre", bus.o_wb_ack, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_ack",   bus.o_wb_ack,  1'b0);
    check("t6_data",  bus.o_wb_data, 32'h0);
    check("t6_ecnt",  err_count,     16'h0);
    check("t6_eaddr", err_addr,      30'h0);
    rst = 1'b0;
    tick();
    check("t6_noack",  bus.o_wb_ack, 1'b0);
    tick();
    check("t6_noack2", bus.o_wb_ack, 1'b0);
    check("t6_noerr",  bus.o_wb_err, 1'b0);
    bus.i_s_ack  = 4'b0000;
    bus.i_wb_cyc = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
